// File: rtl/eight_bit_sh_pkg.sv
// Shared opcode encoding and default width for the eight_bit_sh shift register.
package eight_bit_sh_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

endpackage

// File: rtl/eight_bit_sh_if.sv
// Bundles the data/opcode inputs and registered outputs of eight_bit_sh.
interface eight_bit_sh_if
  import eight_bit_sh_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] myInput;
  logic             shift_input;
  logic [2:0]       operation;
  logic             shift_output;
  logic [WIDTH-1:0] myOutput;

  modport master (
    output myInput, shift_input, operation,
    input  shift_output, myOutput
  );

  modport slave (
    input  myInput, shift_input, operation,
    output shift_output, myOutput
  );
endinterface

// File: rtl/eight_bit_sh_next.sv
// Combinational next-state for the shift register and its serial-out bit.
// Rotate opcodes exist only when EIGHT_BIT_SH_ROTATE_EN is defined; otherwise they hold.
module eight_bit_sh_next
  import eight_bit_sh_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             so,
  input  logic [WIDTH-1:0] my_input,
  input  logic             shift_input,
  input  logic [2:0]       operation,
  output logic [WIDTH-1:0] q_d,
  output logic             so_d
);

  // NOTE: defaults first so every path assigns q_d/so_d and no latch is inferred;
  // unmatched opcodes (including X/Z) fall through to hold.
  always_comb begin
    q_d  = q;
    so_d = so;
    case (operation)
      OP_LOAD: begin
        q_d  = my_input;
        so_d = 1'b0;
      end
      OP_SHR: begin
        q_d  = {shift_input, q[WIDTH-1:1]};
        so_d = q[0];
      end
      OP_SHL: begin
        q_d  = {q[WIDTH-2:0], shift_input};
        so_d = q[WIDTH-1];
      end
`ifdef EIGHT_BIT_SH_ROTATE_EN
      OP_ROR: begin
        q_d  = {q[0], q[WIDTH-1:1]};
        so_d = q[0];
      end
      OP_ROL: begin
        q_d  = {q[WIDTH-2:0], q[WIDTH-1]};
        so_d = q[WIDTH-1];
      end
`endif
      OP_ASR: begin
        q_d  = {q[WIDTH-1], q[WIDTH-1:1]};
        so_d = q[0];
      end
      OP_CLR: begin
        q_d  = '0;
        so_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/eight_bit_sh.sv
// Registered WIDTH-bit shift/rotate register with serial output; state flops and reset only.
// Optional rotate opcodes are enabled by defining EIGHT_BIT_SH_ROTATE_EN.
module eight_bit_sh
  import eight_bit_sh_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] myInput,
  input  logic             shift_input,
  input  logic [2:0]       operation,
  input  logic             clk,
  output logic             shift_output,
  output logic [WIDTH-1:0] myOutput,
  input  logic             rst
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;

  eight_bit_sh_next #(.WIDTH(WIDTH)) u_next (
    .q           (q_q),
    .so          (so_q),
    .my_input    (myInput),
    .shift_input (shift_input),
    .operation   (operation),
    .q_d         (q_d),
    .so_d        (so_d)
  );

  // NOTE: state uses non-blocking assignments; reset is synchronous and overrides any opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign myOutput     = q_q;
  assign shift_output = so_q;

endmodule

// File: tb/tb_eight_bit_sh.sv
// Scoreboard bench for eight_bit_sh: directed vectors push expected results, a monitor compares.
module tb_eight_bit_sh;
  import eight_bit_sh_pkg::*;

  typedef struct {
    logic [7:0] q;
    logic       so;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  eight_bit_sh_if #(.WIDTH(8)) bus ();

  eight_bit_sh #(.WIDTH(8)) dut (
    .myInput      (bus.myInput),
    .shift_input  (bus.shift_input),
    .operation    (bus.operation),
    .clk          (clk),
    .shift_output (bus.shift_output),
    .myOutput     (bus.myOutput),
    .rst          (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge after a vector was issued produces one result to compare.
  initial begin
    exp_t e;
    n_vec = 0;
    n_err = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus.myOutput !== e.q || bus.shift_output !== e.so) begin
          n_err++;
          $display("FAIL %s: got q=%h so=%b, expected q=%h so=%b",
                   e.name, bus.myOutput, bus.shift_output, e.q, e.so);
        end
      end
    end
  end

  task automatic apply(input logic r, input logic [2:0] op, input logic [7:0] din,
                       input logic si, input logic [7:0] eq, input logic eso,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.operation   = op;
    bus.myInput     = din;
    bus.shift_input = si;
    e.q    = eq;
    e.so   = eso;
    e.name = nm;
    sb_q.push_back(e);
  endtask

`ifdef EIGHT_BIT_SH_ROTATE_EN
  logic [7:0] ror_q  [8] = '{8'h89, 8'hC4, 8'h62, 8'h31, 8'h98, 8'h4C, 8'h26, 8'h13};
  logic       ror_so [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    int waited;
    rst             = 1'b0;
    bus.operation   = OP_HOLD;
    bus.myInput     = 8'h00;
    bus.shift_input = 1'b0;

    apply(1'b1, OP_LOAD, 8'hAA, 1'b1, 8'h00, 1'b0, "reset_with_load");
    apply(1'b0, OP_LOAD, 8'h13, 1'b0, 8'h13, 1'b0, "load_13");
`ifdef EIGHT_BIT_SH_ROTATE_EN
    apply(1'b0, OP_ROL,  8'h00, 1'b1, 8'h26, 1'b0, "rol_13");
    apply(1'b0, OP_ASR,  8'h00, 1'b1, 8'h13, 1'b0, "asr_26");
`else
    apply(1'b0, OP_ROL,  8'h00, 1'b1, 8'h13, 1'b0, "rol_disabled_holds");
    apply(1'b0, OP_ASR,  8'h00, 1'b1, 8'h09, 1'b1, "asr_13");
`endif

    apply(1'b0, OP_LOAD, 8'h13, 1'b0, 8'h13, 1'b0, "load_13b");
    apply(1'b0, OP_SHR,  8'h00, 1'b1, 8'h89, 1'b1, "shr_si1");
    apply(1'b0, OP_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, "load_80");
    apply(1'b0, OP_SHL,  8'h00, 1'b1, 8'h01, 1'b1, "shl_si1");

    apply(1'b0, OP_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, "load_81");
    apply(1'b0, OP_ASR,  8'h00, 1'b0, 8'hC0, 1'b1, "asr_81");
    apply(1'b0, OP_ASR,  8'h00, 1'b0, 8'hE0, 1'b0, "asr_c0");

    apply(1'b0, OP_LOAD, 8'h13, 1'b0, 8'h13, 1'b0, "load_13c");
    for (int i = 0; i < 8; i++) begin
`ifdef EIGHT_BIT_SH_ROTATE_EN
      apply(1'b0, OP_ROR, 8'h00, 1'b1, ror_q[i], ror_so[i], $sformatf("ror_%0d", i));
`else
      apply(1'b0, OP_ROR, 8'h00, 1'b1, 8'h13, 1'b0, $sformatf("ror_disabled_%0d", i));
`endif
    end
    apply(1'b0, OP_HOLD, 8'hFF, 1'b1, 8'h13, 1'b0, "hold_after_ror");

    apply(1'b0, OP_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0, "load_ff");
    apply(1'b0, OP_CLR,  8'hAA, 1'b1, 8'h00, 1'b0, "clr");

    // Reset in the middle of a shift sequence, then resume from zero.
    apply(1'b0, OP_LOAD, 8'h5A, 1'b0, 8'h5A, 1'b0, "load_5a");
    apply(1'b0, OP_SHR,  8'h00, 1'b0, 8'h2D, 1'b0, "shr_5a");
    apply(1'b1, OP_SHR,  8'h00, 1'b1, 8'h00, 1'b0, "reset_mid_seq");
    apply(1'b0, OP_SHL,  8'h00, 1'b1, 8'h01, 1'b0, "shl_after_reset");

    // Serial-out bit must hold across HOLD and clear on LOAD.
    apply(1'b0, OP_LOAD, 8'hC3, 1'b0, 8'hC3, 1'b0, "load_c3");
    apply(1'b0, OP_SHL,  8'h00, 1'b0, 8'h86, 1'b1, "shl_c3_si0");
    apply(1'b0, OP_HOLD, 8'h00, 1'b1, 8'h86, 1'b1, "hold_so1_a");
    apply(1'b0, OP_HOLD, 8'h55, 1'b0, 8'h86, 1'b1, "hold_so1_b");
    apply(1'b0, OP_LOAD, 8'h00, 1'b1, 8'h00, 1'b0, "load_clears_so");

    apply(1'b0, OP_LOAD, 8'h01, 1'b0, 8'h01, 1'b0, "load_01");
`ifdef EIGHT_BIT_SH_ROTATE_EN
    apply(1'b0, OP_ROR,  8'h00, 1'b0, 8'h80, 1'b1, "ror_01");
`else
    apply(1'b0, OP_ROR,  8'h00, 1'b0, 8'h01, 1'b0, "ror_disabled_01");
`endif

    @(negedge clk);
    bus.operation = OP_HOLD;
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
